// File: rtl/gate_pair_checker.sv
// gate_pair_checker: sweeps a two-input gate pair through all
// input vectors and counts outputs that differ from AND/OR.
//
// Parameters:
//   NUM_PASSES  full sweeps of the four vectors per run (1..255)
//   SETTLE      cycles each vector is held before sampling (1..15)
//   ERR_W       error counter width (2..16)
//   EXP1_OP     expected function of out1, 0=AND 1=OR
//   EXP2_OP     expected function of out2, 0=AND 1=OR
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       run request, honoured only in IDLE
//   in1, in2    registered stimulus to the gate pair
//   out1, out2  gate results, combinational from in1/in2
//   busy        high in DRIVE and CHECK
//   done        one-cycle pulse in FIN
//   pass        last completed run had no mismatches
//   err_cnt     saturating mismatch count of current/last run

module gate_pair_checker #(
    parameter int NUM_PASSES = 4,
    parameter int SETTLE     = 1,
    parameter int ERR_W      = 8,
    parameter int EXP1_OP    = 0,
    parameter int EXP2_OP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in1,
    output logic             in2,
    input  logic             out1,
    input  logic             out2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0] SET_LAST  = 4'(SETTLE - 1);
    localparam logic [7:0] PASS_LAST = 8'(NUM_PASSES - 1);

    state_t     state;
    logic [1:0] vec_idx;
    logic [7:0] pass_cnt;
    logic [3:0] settle_cnt;

    logic             exp1;
    logic             exp2;
    logic [1:0]       miss;
    logic [ERR_W:0]   err_sum;
    logic [ERR_W-1:0] err_nxt;
    logic [1:0]       vec_nxt;

    // Reference functions are evaluated on the registered stimulus,
    // which is exactly what the gate pair is seeing in CHECK.
    assign exp1 = (EXP1_OP != 0) ? (in1 | in2) : (in1 & in2);
    assign exp2 = (EXP2_OP != 0) ? (in1 | in2) : (in1 & in2);

    assign miss = {1'b0, out1 != exp1} + {1'b0, out2 != exp2};

    // One spare bit catches the overflow; at most +2 is added, so the
    // top bit alone says the count went past all-ones.
    assign err_sum = {1'b0, err_cnt}
                   + {{(ERR_W-1){1'b0}}, miss};
    assign err_nxt = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    assign vec_nxt = vec_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec_idx    <= 2'd0;
            pass_cnt   <= 8'd0;
            settle_cnt <= 4'd0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRIVE;
                        vec_idx    <= 2'd0;
                        pass_cnt   <= 8'd0;
                        settle_cnt <= 4'd0;
                        err_cnt    <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        in1        <= 1'b0;
                        in2        <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SET_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    err_cnt <= err_nxt;
                    if (vec_idx != 2'd3) begin
                        vec_idx <= vec_nxt;
                        in1     <= vec_nxt[1];
                        in2     <= vec_nxt[0];
                        state   <= DRIVE;
                    end else if (pass_cnt < PASS_LAST) begin
                        vec_idx  <= 2'd0;
                        pass_cnt <= pass_cnt + 8'd1;
                        in1      <= 1'b0;
                        in2      <= 1'b0;
                        state    <= DRIVE;
                    end else begin
                        // pass uses the count including this last check
                        vec_idx  <= 2'd0;
                        pass_cnt <= 8'd0;
                        in1      <= 1'b0;
                        in2      <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (err_nxt == '0);
                        state    <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pair_checker.sv
// tb_gate_pair_checker: scoreboard bench for gate_pair_checker,
// three parameter sets driving behavioural gate-pair models.

module tb_gate_pair_checker;

    typedef struct {
        int err;
        int pass;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0=AND 1=OR 2=stuck at 1
    function automatic logic gate(input int m, input logic a,
                                  input logic b);
        case (m)
            0: return a & b;
            1: return a | b;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int model_err(input int np, input int w,
                                     input int m1, input int m2,
                                     input int e1, input int e2);
        int e = 0;
        int sat = (1 << w) - 1;
        for (int p = 0; p < np; p++) begin
            for (int v = 0; v < 4; v++) begin
                logic a = v[1];
                logic b = v[0];
                if (gate(m1, a, b) != gate(e1, a, b)) e++;
                if (gate(m2, a, b) != gate(e2, a, b)) e++;
            end
        end
        if (e > sat) e = sat;
        return e;
    endfunction

    // instance A: defaults
    logic rst_a, start_a, in1_a, in2_a, out1_a, out2_a;
    logic busy_a, done_a, pass_a;
    logic [7:0] err_a;
    int m1a = 0;
    int m2a = 1;
    int a_c = 0;
    assign out1_a = gate(m1a, in1_a, in2_a);
    assign out2_a = gate(m2a, in1_a, in2_a);

    gate_pair_checker u_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .in1(in1_a), .in2(in2_a), .out1(out1_a), .out2(out2_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a)
    );

    // instance B: one pass, out2 wrongly an AND gate
    logic rst_b, start_b, in1_b, in2_b, out1_b, out2_b;
    logic busy_b, done_b, pass_b;
    logic [7:0] err_b;
    assign out1_b = gate(0, in1_b, in2_b);
    assign out2_b = gate(0, in1_b, in2_b);

    gate_pair_checker #(.NUM_PASSES(1)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .in1(in1_b), .in2(in2_b), .out1(out1_b), .out2(out2_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b)
    );

    // instance C: 2-bit counter, out1 stuck at 1, longer settle
    logic rst_c, start_c, in1_c, in2_c, out1_c, out2_c;
    logic busy_c, done_c, pass_c;
    logic [1:0] err_c;
    assign out1_c = gate(2, in1_c, in2_c);
    assign out2_c = gate(1, in1_c, in2_c);

    gate_pair_checker #(.ERR_W(2), .SETTLE(2)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c),
        .in1(in1_c), .in2(in2_c), .out1(out1_c), .out2(out2_c),
        .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_cnt(err_c)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) begin
                chk("a_spurious_done", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_err", err_a, e.err);
                chk("a_pass", pass_a, e.pass);
                chk("a_done_cyc", cyc, e.cyc);
            end
        end
        if (busy_a)
            chk("a_vec", {in1_a, in2_a}, ((cyc - a_c - 1) / 2) % 4);
        else
            chk("a_idle_in", {in1_a, in2_a}, 0);
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (done_b) begin
            if (qb.size() == 0) begin
                chk("b_spurious_done", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_err", err_b, e.err);
                chk("b_pass", pass_b, e.pass);
                chk("b_done_cyc", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (done_c) begin
            if (qc.size() == 0) begin
                chk("c_spurious_done", 1, 0);
            end else begin
                e = qc.pop_front();
                chk("c_err", err_c, e.err);
                chk("c_pass", pass_c, e.pass);
                chk("c_done_cyc", cyc, e.cyc);
            end
        end
    end

    // called at a negedge while A is idle; start is seen at next edge
    task automatic push_a();
        int e = model_err(4, 8, m1a, m2a, 0, 1);
        a_c = cyc;
        qa.push_back('{err: e, pass: (e == 0), cyc: cyc + 33});
    endtask

    task automatic kick_a();
        start_a = 1'b1;
        push_a();
        @(negedge clk);
        start_a = 1'b0;
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic wait_done(input string tag, input int which,
                             input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_of(which) && n < lim);
        if (!done_of(which)) chk(tag, 0, 1);
    endtask

    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        start_a = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);

        // clean run with default parameters
        kick_a();
        chk("a_busy_run", busy_a, 1);
        wait_done("a_to1", 0, 100);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("a_hold_pass", pass_a, 1);
        chk("a_hold_err", err_a, 0);

        // single pass, out2 behaving as AND
        start_b = 1'b1;
        qb.push_back('{err: model_err(1, 8, 0, 0, 0, 1),
                       pass: 0, cyc: cyc + 9});
        @(negedge clk);
        start_b = 1'b0;
        wait_done("b_to", 1, 40);

        // saturation of a 2-bit counter
        @(negedge clk);
        start_c = 1'b1;
        qc.push_back('{err: model_err(4, 2, 2, 1, 0, 1),
                       pass: 0, cyc: cyc + 49});
        @(negedge clk);
        start_c = 1'b0;
        wait_done("c_to", 2, 100);
        repeat (4) @(negedge clk);
        chk("c_hold_err", err_c, 3);
        chk("c_hold_pass", pass_c, 0);

        // reset during the third vector aborts the run
        m2a = 0;
        kick_a();
        n = 0;
        while (!(busy_a && {in1_a, in2_a} == 2'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_third_vec", {in1_a, in2_a}, 2);
        chk("a_pre_rst_err", err_a, 1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        qa.delete();
        chk("a_ab_busy", busy_a, 0);
        chk("a_ab_in", {in1_a, in2_a}, 0);
        chk("a_ab_err", err_a, 0);
        chk("a_ab_done", done_a, 0);
        chk("a_ab_pass", pass_a, 0);
        repeat (40) @(negedge clk);
        chk("a_ab_still_idle", busy_a, 0);

        // full run after the abort
        m2a = 1;
        kick_a();
        wait_done("a_to2", 0, 100);
        @(negedge clk);

        // start re-pulsed mid-run is ignored
        m1a = 1;
        kick_a();
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        start_a = 1'b1;
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        wait_done("a_to3", 0, 100);

        // start high through FIN into IDLE starts a second run
        start_a = 1'b1;
        m1a = 0;
        @(negedge clk);
        chk("a_fin_ignored", busy_a, 0);
        push_a();
        @(negedge clk);
        start_a = 1'b0;
        chk("a_rerun_busy", busy_a, 1);
        chk("a_rerun_err", err_a, 0);
        wait_done("a_to4", 0, 100);
        repeat (3) @(negedge clk);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);
        chk("qc_empty", qc.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
